// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmemState_t  responder FSM states (IDLE, WAIT, RESP)
//   dmemDbg_t    debug snapshot of the FSM (state + latency counter)
//   LAT_CNT_W    width of the latency counter
//   BE_W         number of byte lanes in a 32-bit word
//   ALIGN_BITS / ALIGN_MASK  byte-offset bits of a word-aligned address
//   addrError()  flags misaligned or out-of-range byte addresses
package dmem_pkg;

    localparam int LAT_CNT_W = 4;
    localparam int BE_W      = 4;

    // A word address has its two low byte-offset bits clear.
    localparam int          ALIGN_BITS = 2;
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState_t;

    typedef struct packed {
        dmemState_t             state;
        logic [LAT_CNT_W-1:0]   cnt;
    } dmemDbg_t;

    // Error when the address is not word aligned or reaches beyond the
    // 2^addrW-word array.
    function automatic logic addrError(input logic [31:0] addr, input int addrW);
        return ((addr & ALIGN_MASK) != 32'd0) ||
               ((addr >> (addrW + ALIGN_BITS)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// dmem_sp_ram: single-port 2^ADDR_W x DATA_W array, one synchronous port.
//   clk    rising-edge clock
//   en     port enable; no access when low
//   we     1 = write enabled byte lanes, 0 = read into rdata
//   addr   word address
//   be     per-byte write enables (bit i gates wdata[8i+7:8i])
//   wdata  write data
//   rdata  registered read data; holds its value on writes and idle cycles
// The array has no reset; contents survive a responder reset.
module dmem_sp_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req_valid  request present          req_ready  responder can accept
//   req_we     1 = write, 0 = read      req_addr   byte address
//   req_wdata  write data               req_be     byte enables
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read data (0 for writes and errors)
//   rsp_err    address error, qualifies rsp_valid
//   stall      hold request to the pipeline while an access is outstanding
//   dbgState   FSM state and latency counter snapshot
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so one access is
// outstanding at a time. The response has no backpressure: rsp_valid is high
// for exactly the RESP cycle, LATENCY edges after acceptance, and the
// consumer must take it then.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall,
    output dmemDbg_t          dbgState
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
        if (DATA_W != 32) begin : gBadWidth
            $error("dmem_responder: DATA_W must be 32");
        end
    endgenerate

    localparam bit LAT_ONE = (LATENCY == 1);

    dmemState_t             state, stateNext;
    logic [LAT_CNT_W-1:0]   cnt, cntNext;

    logic                   weQ;
    logic [31:0]            addrQ;
    logic [DATA_W-1:0]      wdataQ;
    logic [BE_W-1:0]        beQ;

    logic                   accept;
    logic                   enterResp;
    logic                   useReq;
    logic                   accWe;
    logic [31:0]            accAddr;
    logic [DATA_W-1:0]      accWdata;
    logic [BE_W-1:0]        accBe;
    logic                   accErr;

    logic                   rspValidQ;
    logic                   rspErrQ;
    logic                   rspDataEnQ;
    logic [DATA_W-1:0]      ramRdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign stall     = ((state == IDLE) & req_valid) | (state == WAIT);
    assign dbgState  = '{state: state, cnt: cnt};

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        enterResp = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LAT_ONE) begin
                        stateNext = RESP;
                        enterResp = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = LAT_CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                    enterResp = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            beQ    <= '0;
        end else if (accept) begin
            weQ    <= req_we;
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
            beQ    <= req_be;
        end
    end

    // With LATENCY==1 the array is accessed on the acceptance edge itself,
    // before the capture registers hold the request, so IDLE uses the live
    // request fields.
    assign useReq   = (state == IDLE);
    assign accWe    = useReq ? req_we    : weQ;
    assign accAddr  = useReq ? req_addr  : addrQ;
    assign accWdata = useReq ? req_wdata : wdataQ;
    assign accBe    = useReq ? req_be    : beQ;
    assign accErr   = addrError(accAddr, ADDR_W);

    // The array is touched only on the edge entering RESP, so a reset that
    // lands before then drops a pending write without side effects.
    dmem_sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uRam (
        .clk   (clk),
        .en    (enterResp & ~accErr),
        .we    (accWe),
        .addr  (accAddr[ADDR_W+ALIGN_BITS-1:ALIGN_BITS]),
        .be    (accBe),
        .wdata (accWdata),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rspValidQ  <= 1'b0;
            rspErrQ    <= 1'b0;
            rspDataEnQ <= 1'b0;
        end else begin
            rspValidQ  <= enterResp;
            rspErrQ    <= enterResp & accErr;
            rspDataEnQ <= enterResp & ~accErr & ~accWe;
        end
    end

    // The RAM output register holds stale data outside RESP; a registered
    // enable that is high only for a successful read forces zero elsewhere.
    assign rsp_valid = rspValidQ;
    assign rsp_err   = rspErrQ;
    assign rsp_rdata = rspDataEnQ ? ramRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus, routed by sel ----------------
  logic        sel;        // 0 = LATENCY 2 instance, 1 = LATENCY 3 instance
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        r2_ready, r2_rsp_valid, r2_rsp_err, r2_stall;
  logic [31:0] r2_rsp_rdata;
  dmemDbg_t    r2_dbg;
  logic        r3_ready, r3_rsp_valid, r3_rsp_err, r3_stall;
  logic [31:0] r3_rsp_rdata;
  dmemDbg_t    r3_dbg;

  logic        v2, v3;
  assign v2 = req_valid & ~sel;
  assign v3 = req_valid & sel;

  logic        o_ready, o_rsp_valid, o_rsp_err, o_stall;
  logic [31:0] o_rsp_rdata;
  assign o_ready     = sel ? r3_ready     : r2_ready;
  assign o_rsp_valid = sel ? r3_rsp_valid : r2_rsp_valid;
  assign o_rsp_err   = sel ? r3_rsp_err   : r2_rsp_err;
  assign o_stall     = sel ? r3_stall     : r2_stall;
  assign o_rsp_rdata = sel ? r3_rsp_rdata : r2_rsp_rdata;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(r2_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rsp_rdata), .rsp_err(r2_rsp_err),
    .stall(r2_stall), .dbgState(r2_dbg)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err),
    .stall(r3_stall), .dbgState(r3_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver ----------------
  // Issues one request, returns what was observed: latency in edges from
  // acceptance (0 = no response within budget), data, error, whether stall
  // and ready behaved through the access, and whether outputs were quiet in
  // the cycle after the response.
  task automatic txn(input logic s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic stall_ok, output logic post_ok);
    @(negedge clk);
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    #1;
    stall_ok = (o_stall === 1'b1) && (o_ready === 1'b1);
    lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx; post_ok = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (o_rsp_valid === 1'b1) begin
        lat = k; rdata = o_rsp_rdata; err = o_rsp_err;
        if (o_stall !== 1'b0 || o_ready !== 1'b0) stall_ok = 1'b0;
        break;
      end else if (o_stall !== 1'b1 || o_ready !== 1'b0) begin
        stall_ok = 1'b0;
      end
    end
    @(negedge clk);
    post_ok = (o_rsp_valid === 1'b0) && (o_rsp_rdata === 32'd0) &&
              (o_rsp_err === 1'b0) && (o_ready === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({r2_ready, r3_ready} !== 2'b11) begin
        bad++; $display("FAIL reset_ready c=%0d: got %b want 11", c, {r2_ready, r3_ready});
      end
      total++;
      if ({r2_stall, r3_stall} !== 2'b00) begin
        bad++; $display("FAIL reset_stall c=%0d: got %b want 00", c, {r2_stall, r3_stall});
      end
      total++;
      if ({r2_rsp_valid, r3_rsp_valid, r2_rsp_err, r3_rsp_err} !== 4'b0000) begin
        bad++; $display("FAIL reset_rsp c=%0d: got %b want 0000", c,
                        {r2_rsp_valid, r3_rsp_valid, r2_rsp_err, r3_rsp_err});
      end
      total++;
      if (r2_rsp_rdata !== 32'd0 || r3_rsp_rdata !== 32'd0) begin
        bad++; $display("FAIL reset_rdata c=%0d: got %h/%h want 0", c, r2_rsp_rdata, r3_rsp_rdata);
      end
      total++;
      if (r2_dbg.state !== IDLE || r3_dbg.state !== IDLE) begin
        bad++; $display("FAIL reset_state c=%0d: got %0d/%0d want 0", c, r2_dbg.state, r3_dbg.state);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int l; logic so, po;
    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, d, e, l, so, po);
    total++; if (l !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", l); end
    total++; if (d !== 32'd0) begin bad++; $display("FAIL wr_rdata: got %h want 0", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL wr_stall_ready: got %b want 1", so); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL wr_post_quiet: got %b want 1", po); end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, l, so, po);
    total++; if (l !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", l); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", e); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL rd_stall_ready: got %b want 1", so); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL rd_post_quiet: got %b want 1", po); end
  endtask

  task automatic test_partial_write();
    logic [31:0] d; logic e; int l; logic so, po;
    txn(1'b0, 1'b1, 32'h10, 32'h0000_0055, 4'b0001, d, e, l, so, po);
    total++; if (l !== 2 || d !== 32'd0) begin
      bad++; $display("FAIL pw_resp: got lat=%0d data=%h want lat=2 data=0", l, d);
    end
    // be=0 is a legal no-op write that still answers
    txn(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, d, e, l, so, po);
    total++; if (l !== 2 || e !== 1'b0) begin
      bad++; $display("FAIL be0_resp: got lat=%0d err=%b want lat=2 err=0", l, e);
    end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, d, e, l, so, po);
    total++; if (d !== 32'hDEAD_BE55) begin
      bad++; $display("FAIL pw_readback: got %h want deadbe55", d);
    end
  endtask

  task automatic test_addr_error();
    logic [31:0] d; logic e; int l; logic so, po;
    txn(1'b0, 1'b0, 32'h12, 32'h0, 4'hF, d, e, l, so, po);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL misalign_err: got %b want 1", e); end
    total++; if (d !== 32'd0) begin bad++; $display("FAIL misalign_rdata: got %h want 0", d); end
    total++; if (l !== 2) begin bad++; $display("FAIL misalign_latency: got %0d want 2", l); end
    txn(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, d, e, l, so, po);
    total++; if (e !== 1'b1 || d !== 32'd0 || l !== 2) begin
      bad++; $display("FAIL range_err: got err=%b data=%h lat=%0d want err=1 data=0 lat=2", e, d, l);
    end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL err_post_quiet: got %b want 1", po); end
    // a misaligned write into word 4 must not land
    txn(1'b0, 1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, d, e, l, so, po);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL wr_misalign_err: got %b want 1", e); end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, d, e, l, so, po);
    total++; if (d !== 32'hDEAD_BE55 || e !== 1'b0) begin
      bad++; $display("FAIL err_mem_unchanged: got %h err=%b want deadbe55 err=0", d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int l; logic so, po;
    logic [31:0] vals [4];
    int idx, last_acc;
    logic advance, exp_ready, exp_stall, exp_rsp;
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0004;
    vals[2] = 32'h3333_0008; vals[3] = 32'h4444_000C;
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 32'(i * 4), vals[i], 4'hF, d, e, l, so, po);
      total++; if (l !== 3) begin bad++; $display("FAIL l3_preload_latency i=%0d: got %0d want 3", i, l); end
    end
    exp_q.delete();
    @(negedge clk);
    sel = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'd0; req_valid = 1'b1;
    idx = 0; last_acc = -1; advance = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      if (advance) begin
        idx++; advance = 1'b0;
        if (idx == 4) req_valid = 1'b0;
        else req_addr = 32'(idx * 4);
      end
      #1;
      exp_ready = (last_acc < 0) || (c - last_acc >= 4);
      exp_rsp   = (last_acc >= 0) && (c == last_acc + 3);
      exp_stall = exp_ready ? req_valid : (c - last_acc < 3);
      total++;
      if (o_ready !== exp_ready) begin
        bad++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, o_ready, exp_ready);
      end
      total++;
      if (o_stall !== exp_stall) begin
        bad++; $display("FAIL b2b_stall c=%0d: got %b want %b", c, o_stall, exp_stall);
      end
      total++;
      if (o_rsp_valid !== exp_rsp) begin
        bad++; $display("FAIL b2b_rsp_valid c=%0d: got %b want %b", c, o_rsp_valid, exp_rsp);
      end
      if (exp_rsp) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_underflow c=%0d: got empty want entry", c);
        end else begin
          d = exp_q.pop_front();
          if (o_rsp_rdata !== d || o_rsp_err !== 1'b0) begin
            bad++; $display("FAIL b2b_data c=%0d: got %h err=%b want %h err=0", c, o_rsp_rdata, o_rsp_err, d);
          end
        end
      end
      if (exp_ready && req_valid) begin
        exp_q.push_back(vals[idx]);
        last_acc = c;
        advance = 1'b1;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int l; logic so, po;
    txn(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, d, e, l, so, po);
    total++; if (l !== 2) begin bad++; $display("FAIL preload20_latency: got %0d want 2", l); end
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL mid_wait_stall: got %b want 1", o_stall); end
    rst = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1 || o_stall !== 1'b0) begin
      bad++; $display("FAIL mid_reset_idle: got ready=%b stall=%b want 1/0", o_ready, o_stall);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (o_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL mid_no_rsp c=%0d: got %b want 0", c, o_rsp_valid);
      end
    end
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, d, e, l, so, po);
    total++; if (d !== 32'd0 || l !== 2) begin
      bad++; $display("FAIL mid_mem_unchanged: got %h lat=%0d want 0 lat=2", d, l);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_addr_error();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
